// File: rtl/pwm_decoder.sv
// Measures high time and period of an asynchronous PWM input in prescaled ticks.
// Latency: valid pulses 4 clk after the closing rising edge is sampled; no backpressure, updates are fire-and-forget.
module pwm_decoder #(
    parameter int SLOW_CLOCK_BITS = 13,
    parameter int TIMEOUT_TICKS   = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    input  logic       en,
    output logic [7:0] duty_cycle,
    output logic [8:0] period,
    output logic       valid,
    output logic       signal_lost
);

    localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                       sync_1;
    logic                       sync_2;
    logic                       sync_3;
    logic                       rise_raw;
    logic                       fall_raw;
    logic                       rise_evt;
    logic                       fall_evt;
    logic                       edge_evt;
    logic [SLOW_CLOCK_BITS-1:0] presc;
    logic                       tick;
    logic                       timeout;
    logic                       latch;
    logic [7:0]                 high_cnt;
    logic [8:0]                 per_cnt;
    logic [IDLE_W-1:0]          idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= pwm_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign rise_raw = sync_2 & ~sync_3;
    assign fall_raw = ~sync_2 & sync_3;

    // Prescaler clears one cycle ahead of the registered edge, so a tick
    // lands on the last cycle of every full tick interval of the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_evt <= 1'b0;
            fall_evt <= 1'b0;
            presc    <= '0;
        end else begin
            rise_evt <= rise_raw;
            fall_evt <= fall_raw;
            if (rise_raw || fall_raw) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign edge_evt = rise_evt | fall_evt;
    assign tick     = (&presc) & ~edge_evt;
    assign timeout  = en && (state != IDLE) && tick && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise_evt) begin
                        state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (timeout) begin
                        state_nxt = WAIT_RISE;
                    end else if (fall_evt) begin
                        state_nxt = LOW;
                    end
                end
                LOW: begin
                    if (timeout) begin
                        state_nxt = WAIT_RISE;
                    end else if (rise_evt) begin
                        state_nxt = HIGH;
                        latch     = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt <= '0;
            per_cnt  <= '0;
            idle_cnt <= '0;
        end else if (!en || state == IDLE) begin
            high_cnt <= '0;
            per_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            if (edge_evt) begin
                idle_cnt <= '0;
            end else if (tick && idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (timeout) begin
                high_cnt <= '0;
                per_cnt  <= '0;
            end else begin
                case (state)
                    WAIT_RISE: begin
                        if (rise_evt) begin
                            high_cnt <= '0;
                            per_cnt  <= '0;
                        end
                    end
                    HIGH: begin
                        if (tick) begin
                            if (high_cnt != 8'hFF) begin
                                high_cnt <= high_cnt + 8'd1;
                            end
                            if (per_cnt != 9'h1FF) begin
                                per_cnt <= per_cnt + 9'd1;
                            end
                        end
                    end
                    LOW: begin
                        if (rise_evt) begin
                            high_cnt <= '0;
                            per_cnt  <= '0;
                        end else if (tick && per_cnt != 9'h1FF) begin
                            per_cnt <= per_cnt + 9'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Outputs only move on a completed period or a timeout; en low freezes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_cycle  <= '0;
            period      <= '0;
            valid       <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            valid <= latch;
            if (latch) begin
                duty_cycle  <= high_cnt;
                period      <= per_cnt;
                signal_lost <= 1'b0;
            end else if (timeout) begin
                signal_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench: dut_s uses a short timeout, dut_l a long one for long periods and saturation.
module tb_pwm_decoder;

    localparam int SB   = 4;
    localparam int TICK = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       pwm_s = 1'b0;
    logic       pwm_l = 1'b0;
    logic [7:0] duty_s;
    logic [8:0] period_s;
    logic       valid_s;
    logic       lost_s;
    logic [7:0] duty_l;
    logic [8:0] period_l;
    logic       valid_l;
    logic       lost_l;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] q_s[$];
    logic [16:0] q_l[$];
    bit          armed [2];
    int          pend_h[2];
    int          pend_l[2];

    always #5 clk = ~clk;

    pwm_decoder #(.SLOW_CLOCK_BITS(SB), .TIMEOUT_TICKS(64)) dut_s (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_s), .en(en),
        .duty_cycle(duty_s), .period(period_s), .valid(valid_s), .signal_lost(lost_s)
    );

    pwm_decoder #(.SLOW_CLOCK_BITS(SB), .TIMEOUT_TICKS(1024)) dut_l (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_l), .en(en),
        .duty_cycle(duty_l), .period(period_l), .valid(valid_l), .signal_lost(lost_l)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] exp_val(input int h, input int l);
        int d;
        int p;
        d = h / TICK;
        p = h / TICK + l / TICK;
        if (d > 255) d = 255;
        if (p > 511) p = 511;
        return {d[7:0], p[8:0]};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pwm(input int sel, input logic v);
        if (sel == 0) pwm_s = v;
        else          pwm_l = v;
    endtask

    // A rising edge closes the previous period if the decoder was mid-measurement.
    task automatic start_period(input int sel, input int h, input int l);
        if (armed[sel]) begin
            if (sel == 0) q_s.push_back(exp_val(pend_h[sel], pend_l[sel]));
            else          q_l.push_back(exp_val(pend_h[sel], pend_l[sel]));
        end
        armed[sel]  = 1'b1;
        pend_h[sel] = h;
        pend_l[sel] = l;
        set_pwm(sel, 1'b1);
    endtask

    task automatic drive(input int sel, input int h, input int l);
        start_period(sel, h, l);
        wait_clk(h);
        set_pwm(sel, 1'b0);
        wait_clk(l);
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (valid_s) begin
            chk("s_valid_expected", int'(q_s.size() != 0), 1);
            if (q_s.size() != 0) begin
                e = q_s.pop_front();
                chk("s_duty", int'(duty_s), int'(e[16:9]));
                chk("s_period", int'(period_s), int'(e[8:0]));
                chk("s_lost_at_valid", int'(lost_s), 0);
            end
        end
        if (valid_l) begin
            chk("l_valid_expected", int'(q_l.size() != 0), 1);
            if (q_l.size() != 0) begin
                e = q_l.pop_front();
                chk("l_duty", int'(duty_l), int'(e[16:9]));
                chk("l_period", int'(period_l), int'(e[8:0]));
                chk("l_lost_at_valid", int'(lost_l), 0);
            end
        end
    end

    initial begin
        armed[0] = 1'b0;
        armed[1] = 1'b0;
        #2;
        rst_n = 1'b0;
        en    = 1'b1;
        wait_clk(4);
        chk("s_rst_duty", int'(duty_s), 0);
        chk("s_rst_period", int'(period_s), 0);
        chk("s_rst_valid", int'(valid_s), 0);
        chk("s_rst_lost", int'(lost_s), 1);
        chk("l_rst_lost", int'(lost_l), 1);
        rst_n = 1'b1;
        wait_clk(20);

        // Constant levels never yield a measurement.
        wait_clk(1200);
        chk("s_const_low_lost", int'(lost_s), 1);
        set_pwm(0, 1'b1);
        wait_clk(1500);
        chk("s_const_high_lost", int'(lost_s), 1);
        set_pwm(0, 1'b0);
        wait_clk(200);

        // Normal run including a sub-tick glitch, then hold low into timeout.
        drive(0, 192, 800);
        drive(0, 8, 800);
        drive(0, 192, 800);
        drive(0, 384, 640);
        drive(0, 192, 800);
        chk("s_lost_running", int'(lost_s), 0);
        wait_clk(300);
        chk("s_timeout_lost", int'(lost_s), 1);
        chk("s_timeout_duty_hold", int'(duty_s), 24);
        chk("s_timeout_period_hold", int'(period_s), 64);
        armed[0] = 1'b0;

        // Reset in the middle of a high phase.
        drive(0, 192, 800);
        start_period(0, 192, 800);
        wait_clk(100);
        rst_n = 1'b0;
        wait_clk(5);
        chk("s_midrst_duty", int'(duty_s), 0);
        chk("s_midrst_period", int'(period_s), 0);
        chk("s_midrst_valid", int'(valid_s), 0);
        chk("s_midrst_lost", int'(lost_s), 1);
        wait_clk(87);
        set_pwm(0, 1'b0);
        wait_clk(100);
        rst_n = 1'b1;
        armed[0] = 1'b0;
        wait_clk(50);
        drive(0, 192, 800);
        drive(0, 192, 800);

        // Enable dropped for 10 cycles during a low phase.
        start_period(0, 192, 800);
        wait_clk(192);
        set_pwm(0, 1'b0);
        wait_clk(400);
        en = 1'b0;
        wait_clk(5);
        chk("s_en_hold_duty", int'(duty_s), 12);
        chk("s_en_hold_period", int'(period_s), 62);
        wait_clk(5);
        en = 1'b1;
        armed[0] = 1'b0;
        wait_clk(395);
        drive(0, 192, 800);
        drive(0, 192, 800);
        wait_clk(50);

        // Long periods and saturation on the long-timeout decoder.
        drive(1, 192, 1600);
        drive(1, 192, 1600);
        chk("l_lost_cleared", int'(lost_l), 0);
        drive(1, 384, 1408);
        drive(1, 5000, 4000);
        drive(1, 5000, 4000);
        start_period(1, 192, 100);
        wait_clk(192);
        set_pwm(1, 1'b0);
        wait_clk(100);

        chk("s_leftover", q_s.size(), 0);
        chk("l_leftover", q_l.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
